// File: rtl/ntt_bu_sched.sv
// ntt_bu_sched: address sequencer for in-place radix-2 NTT passes.
//
// Walks every stage of a 2^LOG_N-point transform and issues one butterfly
// per cycle as a read-address pair plus a twiddle index. Each issued pair
// is delayed by PIPE_LAT cycles and presented again as the write-back pair.
// After the last butterfly of a stage the sequencer drains for PIPE_LAT
// cycles, so every write of a stage lands before the next stage reads.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle run request, accepted only in IDLE
//   stall               freezes sequencing and the write-back delay line
//   busy                high from the first ISSUE cycle to the last DRAIN cycle
//   done                one-cycle pulse after the final write-back
//   rd_en               read pair valid
//   rd_addr0/rd_addr1   upper/lower butterfly operand addresses
//   tw_idx              twiddle ROM index for the issued butterfly
//   stage_o             current stage number
//   wr_en               write-back pair valid
//   wr_addr0/wr_addr1   destinations of the butterfly results
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | one butterfly read per non-stalled cycle, j = 0 .. N/2-1
// DRAIN | PIPE_LAT non-stalled cycles with no reads, writes complete
// DONE  | done pulse, then back to IDLE

module ntt_bu_sched #(
    parameter int LOG_N    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr0,
    output logic [LOG_N-1:0]           rd_addr1,
    output logic [LOG_N-2:0]           tw_idx,
    output logic [$clog2(LOG_N)-1:0]   stage_o,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr0,
    output logic [LOG_N-1:0]           wr_addr1
);

    localparam int N    = 1 << LOG_N;
    localparam int HALF = N / 2;
    localparam int JW   = LOG_N - 1;
    localparam int SW   = $clog2(LOG_N);
    localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [LOG_N-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   drain_q, drain_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. start is accepted in IDLE even while stalled;
    // every other transition waits for stall to drop.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (j_q == JW'(HALF - 1)) begin
                        state_d = DRAIN;
                        drain_d = DW'(PIPE_LAT - 1);
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_q == '0) begin
                        if (stage_q == SW'(LOG_N - 1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE;
                            stage_d = stage_q + 1'b1;
                            j_d     = '0;
                        end
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Butterfly address generation for stage s, butterfly j:
    //   span = N >> (s+1), group = j >> (LOG_N-1-s), offset = j & (span-1)
    //   addr0 = group << (LOG_N-s) | offset, addr1 = addr0 + span
    //   twiddle = offset << s
    // ------------------------------------------------------------------
    int               sh;
    logic [LOG_N-1:0] j_ext;
    logic [LOG_N-1:0] span;
    logic [LOG_N-1:0] grp;
    logic [LOG_N-1:0] offs;
    logic [LOG_N-1:0] a0;
    logic [JW-1:0]    tw_c;

    always_comb begin
        sh    = LOG_N - 1 - int'(stage_q);
        j_ext = {1'b0, j_q};
        span  = ONE << sh;
        grp   = j_ext >> sh;
        offs  = j_ext & (span - ONE);
        a0    = (grp << (sh + 1)) | offs;
        tw_c  = offs[JW-1:0] << stage_q;
    end

    logic in_issue;
    assign in_issue = (state_q == ISSUE);

    // Addresses stay on the outputs while a stalled issue waits, so the
    // blocked butterfly is re-presented unchanged once stall drops.
    assign rd_en    = in_issue && !stall;
    assign rd_addr0 = in_issue ? a0 : '0;
    assign rd_addr1 = in_issue ? (a0 + span) : '0;
    assign tw_idx   = in_issue ? tw_c : '0;
    assign stage_o  = stage_q;
    assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    // ------------------------------------------------------------------
    // Write-back delay line: advances only on non-stalled cycles, so the
    // write for an issue appears exactly PIPE_LAT advancing cycles later.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] dl_vld;
    logic [LOG_N-1:0]    dl_a0 [PIPE_LAT];
    logic [LOG_N-1:0]    dl_a1 [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_a0[i] <= '0;
                dl_a1[i] <= '0;
            end
        end else if (!stall) begin
            dl_vld[0] <= rd_en;
            dl_a0[0]  <= rd_addr0;
            dl_a1[0]  <= rd_addr1;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_a0[i]  <= dl_a0[i-1];
                dl_a1[i]  <= dl_a1[i-1];
            end
        end
    end

    assign wr_en    = dl_vld[PIPE_LAT-1] && !stall;
    assign wr_addr0 = dl_a0[PIPE_LAT-1];
    assign wr_addr1 = dl_a1[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_bu_sched.sv
// Testbench for ntt_bu_sched: one LOG_N=3/PIPE_LAT=2 instance driven by
// directed runs and checked through a read/write scoreboard, plus two
// LOG_N=4 instances (PIPE_LAT=1 and 5) checked for write coverage and
// busy length.

module tb_ntt_bu_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, stall, start_s, stall_s;

    logic       busy, done, rd_en, wr_en;
    logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [1:0] tw_idx, stage_o;

    logic       busy_a, done_a, rd_en_a, wr_en_a;
    logic [3:0] rd_addr0_a, rd_addr1_a, wr_addr0_a, wr_addr1_a;
    logic [2:0] tw_idx_a;
    logic [1:0] stage_o_a;

    logic       busy_b, done_b, rd_en_b, wr_en_b;
    logic [3:0] rd_addr0_b, rd_addr1_b, wr_addr0_b, wr_addr1_b;
    logic [2:0] tw_idx_b;
    logic [1:0] stage_o_b;

    ntt_bu_sched #(.LOG_N(3), .PIPE_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_idx(tw_idx),
        .stage_o(stage_o), .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    ntt_bu_sched #(.LOG_N(4), .PIPE_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s), .stall(stall_s),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
        .rd_addr0(rd_addr0_a), .rd_addr1(rd_addr1_a), .tw_idx(tw_idx_a),
        .stage_o(stage_o_a), .wr_en(wr_en_a),
        .wr_addr0(wr_addr0_a), .wr_addr1(wr_addr1_a)
    );

    ntt_bu_sched #(.LOG_N(4), .PIPE_LAT(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s), .stall(stall_s),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
        .rd_addr0(rd_addr0_b), .rd_addr1(rd_addr1_b), .tw_idx(tw_idx_b),
        .stage_o(stage_o_b), .wr_en(wr_en_b),
        .wr_addr0(wr_addr0_b), .wr_addr1(wr_addr1_b)
    );

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard queues: rd entry {stage, addr0, addr1, tw}, wr entry {addr0, addr1}
    logic [9:0] rdq[$];
    logic [5:0] wrq[$];

    // Hand-derived butterfly schedule for an 8-point transform
    task automatic push_run();
        logic [2:0] e0 [12];
        logic [2:0] e1 [12];
        logic [1:0] et [12];
        e0 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4, 3'd6};
        e1 = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};
        et = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 12; i++) begin
            rdq.push_back({2'(i / 4), e0[i], e1[i], et[i]});
            wrq.push_back({e0[i], e1[i]});
        end
    endtask

    int busy_cnt = 0;
    int done_cnt = 0;
    bit prev_wr  = 1'b0;

    // Monitor for the main instance
    initial begin
        logic [9:0] er;
        logic [5:0] ew;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (stall) begin
                chk("rd_en_in_stall", 32'(rd_en), 32'd0);
                chk("wr_en_in_stall", 32'(wr_en), 32'd0);
            end
            if (rd_en) begin
                if (rdq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rd_extra: got pair (%0d,%0d), expected no read",
                             rd_addr0, rd_addr1);
                end else begin
                    er = rdq.pop_front();
                    chk("rd_pair", 32'({stage_o, rd_addr0, rd_addr1, tw_idx}), 32'(er));
                end
            end
            if (wr_en) begin
                if (wrq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL wr_extra: got pair (%0d,%0d), expected no write",
                             wr_addr0, wr_addr1);
                end else begin
                    ew = wrq.pop_front();
                    chk("wr_pair", 32'({wr_addr0, wr_addr1}), 32'(ew));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_after_last_wr", 32'(prev_wr), 32'd1);
            end
            prev_wr = wr_en;
        end
    end

    // Monitors for the sweep instances: writes counted per stage by arrival order
    int busy_a_cnt = 0, done_a_cnt = 0, wseen_a = 0;
    int busy_b_cnt = 0, done_b_cnt = 0, wseen_b = 0;
    int cnt_a [4][16];
    int cnt_b [4][16];

    initial begin
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++) begin
                cnt_a[s][a] = 0;
                cnt_b[s][a] = 0;
            end
        forever begin
            @(negedge clk);
            if (busy_a) busy_a_cnt++;
            if (done_a) done_a_cnt++;
            if (wr_en_a) begin
                if (wseen_a < 32) begin
                    cnt_a[wseen_a / 8][wr_addr0_a]++;
                    cnt_a[wseen_a / 8][wr_addr1_a]++;
                end
                wseen_a++;
            end
            if (busy_b) busy_b_cnt++;
            if (done_b) done_b_cnt++;
            if (wr_en_b) begin
                if (wseen_b < 32) begin
                    cnt_b[wseen_b / 8][wr_addr0_b]++;
                    cnt_b[wseen_b / 8][wr_addr1_b]++;
                end
                wseen_b++;
            end
        end
    end

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_latency", 32'({busy, rd_en}), 32'b11);
    endtask

    task automatic wait_done(input int target, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        if (done_cnt < target) begin
            nvec++; nerr++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_run_end(input string name, input int exp_busy, input int exp_done);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
        chk({name, "_rd_left"}, 32'(rdq.size()), 32'd0);
        chk({name, "_wr_left"}, 32'(wrq.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        start_s = 1'b0;
        stall_s = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("outputs_in_reset", 32'({busy, done, rd_en, wr_en, rd_addr0, rd_addr1}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs",
            32'({busy, done, rd_en, wr_en, rd_addr0, rd_addr1, tw_idx, stage_o, wr_addr0, wr_addr1}),
            32'd0);
        chk("reset_outputs_sweep",
            32'({busy_a, wr_en_a, rd_addr1_a, busy_b, wr_en_b, rd_addr1_b}), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_start", 32'({busy, rd_en, wr_en, done}), 32'd0);

        // Full run
        push_run();
        busy_cnt = 0;
        start_run();
        wait_done(1, 40, "run_full");
        check_run_end("run_full", 18, 1);

        // Stall three cycles at stage 1, j=2
        push_run();
        busy_cnt = 0;
        start_run();
        repeat (8) @(posedge clk);
        #1;
        stall = 1'b1;
        #1;
        chk("stall_hold_addr", 32'({rd_en, rd_addr0, rd_addr1}), 32'({1'b0, 3'd4, 3'd6}));
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        #1;
        chk("stall_resume_pair", 32'({rd_en, rd_addr0, rd_addr1}), 32'({1'b1, 3'd4, 3'd6}));
        wait_done(2, 40, "run_stall");
        check_run_end("run_stall", 21, 2);

        // start pulse while busy is ignored
        push_run();
        busy_cnt = 0;
        start_run();
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, 40, "run_restart");
        repeat (25) @(posedge clk);
        check_run_end("run_restart", 18, 3);

        // Reset during stage-1 DRAIN
        push_run();
        busy_cnt = 0;
        start_run();
        repeat (10) @(posedge clk);
        #1;
        chk("in_stage1_drain", 32'({busy, rd_en, wr_en, stage_o}), 32'({1'b1, 1'b0, 1'b1, 2'd1}));
        rst_n = 1'b0;
        #1;
        chk("rst_clears_outputs",
            32'({busy, done, rd_en, wr_en, rd_addr0, rd_addr1, tw_idx, stage_o, wr_addr0, wr_addr1}),
            32'd0);
        chk("rst_rd_left", 32'(rdq.size()), 32'd4);
        chk("rst_wr_left", 32'(wrq.size()), 32'd6);
        rdq.delete();
        wrq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'({busy, rd_en, wr_en, done}), 32'd0);
        push_run();
        busy_cnt = 0;
        start_run();
        wait_done(4, 40, "run_after_rst");
        check_run_end("run_after_rst", 18, 4);

        // Parameter sweep, LOG_N=4 with PIPE_LAT=1 and 5
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            if (done_a_cnt >= 1 && done_b_cnt >= 1) break;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("sweep_lat1_busy", 32'(busy_a_cnt), 32'd36);
        chk("sweep_lat5_busy", 32'(busy_b_cnt), 32'd52);
        chk("sweep_lat1_done", 32'(done_a_cnt), 32'd1);
        chk("sweep_lat5_done", 32'(done_b_cnt), 32'd1);
        chk("sweep_lat1_writes", 32'(wseen_a), 32'd32);
        chk("sweep_lat5_writes", 32'(wseen_b), 32'd32);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++) begin
                chk($sformatf("sweep_lat1_cov_s%0d_a%0d", s, a), 32'(cnt_a[s][a]), 32'd1);
                chk($sformatf("sweep_lat5_cov_s%0d_a%0d", s, a), 32'(cnt_b[s][a]), 32'd1);
            end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ntt_bu_sched.md
# ntt_bu_sched

Sequencer for in-place radix-2 NTT passes through the modular butterfly unit. It walks all LOG_N stages of a 2^LOG_N-point transform and issues one butterfly per cycle: a read-address pair plus a twiddle index. It delays each issued pair by the datapath latency and presents it as a write-back address pair. A start/busy/done handshake and a global stall let the top-level controller and the memory subsystem pace the transform.

## Interface
- LOG_N, default 4: log2 of transform size N; address width is LOG_N; legal range 2..12.
- PIPE_LAT, default 3: cycles from rd_en to the matching write-back (memory read + multiplier + butterfly); legal range ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a full transform; honoured only in IDLE.
- stall  in  1  freezes all sequencing and the write-back delay line while high.
- busy  out  1  high from the first ISSUE cycle through the last DRAIN cycle.
- done  out  1  one-cycle pulse after the final write-back.
- rd_en  out  1  read-pair valid.
- rd_addr0 / rd_addr1  out  LOG_N  upper/lower butterfly operand addresses.
- tw_idx  out  LOG_N-1  twiddle ROM index for the issued butterfly.
- stage_o  out  ceil(log2(LOG_N))  current stage number.
- wr_en  out  1  write-back pair valid.
- wr_addr0 / wr_addr1  out  LOG_N  destinations for the butterfly add/sub results.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 moves to ISSUE with stage=0 and j=0.
  - ISSUE: lasts N/2 non-stalled cycles, one butterfly per cycle, j from 0 to N/2-1. After j=N/2-1 it moves to DRAIN.
  - DRAIN: lasts PIPE_LAT non-stalled cycles with no reads. At the end, if stage<LOG_N-1 it increments stage, clears j and returns to ISSUE; otherwise it moves to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Address generation for stage s and butterfly j:
  - span = N>>(s+1)
  - group = j>>(LOG_N-1-s)
  - offset = j & (span-1)
  - rd_addr0 = (group<<(LOG_N-s)) | offset
  - rd_addr1 = rd_addr0 + span
  - tw_idx = offset<<s
  - All arithmetic is unsigned and exact at LOG_N bits; no wrap occurs for legal j.
- Write-back: a PIPE_LAT-deep shift register carries {valid, addr0, addr1}. wr_en/wr_addr* equal the rd_en/rd_addr* values issued PIPE_LAT advancing cycles earlier.
- DRAIN guarantees every write of stage s lands before any read of stage s+1, so there is no RAW hazard.
- stall=1:
  - FSM, counters and delay line hold their state.
  - rd_en and wr_en are forced to 0 during the stall cycle.
  - Addresses hold their values.
  - An issue blocked by a stall is re-presented when stall drops; nothing is lost or duplicated.
- start while busy or in DONE is ignored. start coincident with stall in IDLE is still accepted.

## Timing
- Reset values: state=IDLE, stage=0, j=0, delay-line valids=0. All outputs are 0 (busy, done, rd_en, wr_en, addresses, tw_idx, stage_o).
- start sampled in cycle t → first rd_en in cycle t+1, with busy=1 from t+1.
- Stalled cycles extend the schedule one for one. Total busy cycles with no stall = LOG_N·(N/2+PIPE_LAT).
- The last wr_en occurs in the final DRAIN cycle. done is high in the following cycle, with busy=0 in that cycle.
- The first wr_en of each stage occurs PIPE_LAT cycles after that stage's first rd_en.
- Reset asserted mid-operation clears everything immediately, including pending write-backs. No wr_en follows reset.

## Test plan
- Reset/idle (LOG_N=3, PIPE_LAT=2): all outputs 0 after rst_n release; no activity without start.
- Full run (LOG_N=3, PIPE_LAT=2): start → exactly 18 busy cycles, then a single done pulse.
  - Stage 0 pairs: (0,4),(1,5),(2,6),(3,7); tw 0,1,2,3.
  - Stage 1 pairs: (0,2),(1,3),(4,6),(5,7); tw 0,2,0,2.
  - Stage 2 pairs: (0,1),(2,3),(4,5),(6,7); tw 0.
  - wr pairs match the read pairs, each 2 cycles later.
- Stall: hold stall for 3 cycles during stage 1 at j=2 → rd_en=wr_en=0 during the stall; sequence resumes at (4,6); total busy cycles = 21; no pair is missing or duplicated.
- start while busy: pulse start mid-stage 0 → no restart and exactly one done.
- Reset mid-DRAIN: rst_n low in the stage-1 DRAIN → outputs 0 immediately, no further wr_en. A new start then yields a clean 18-cycle run.
- Parameter sweep (LOG_N=4, PIPE_LAT=1 and 5): every address 0..15 is written exactly once per stage; busy lengths are 36 and 52 cycles respectively.
